// File: rtl/symbol_tallier.sv
// Streaming per-symbol frequency counter: tallies a frame of symbols, then drains all counts in symbol order.
// Optional build macro TALLY_SAT_EN: counters saturate and record a sticky per-symbol overflow flag.
module symbol_tallier #(
  parameter int SYM_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SYM_W-1:0]       in_sym,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SYM_W-1:0]       out_sym,
  output logic [CNT_W-1:0]       out_count,
  output logic                   out_last,
  output logic [CNT_W+SYM_W-1:0] out_total,
  output logic                   out_ovf,
  output logic                   busy
);

  localparam int NSYM  = 1 << SYM_W;
  localparam int TOT_W = CNT_W + SYM_W;

  typedef enum logic [1:0] {CLEAR, COUNT, DRAIN} state_t;

  state_t           state, state_d;
  logic [SYM_W-1:0] idx, idx_d;
  logic [TOT_W-1:0] total;
  logic [CNT_W-1:0] cnt_mem [NSYM];
  logic [CNT_W-1:0] cnt_cur, cnt_next;
  logic             in_hs, out_hs, idx_max;

  assign in_hs   = in_valid & (state == COUNT);
  assign out_hs  = out_ready & (state == DRAIN);
  assign idx_max = &idx;
  assign cnt_cur = cnt_mem[in_sym];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      CLEAR: begin
        idx_d = idx + SYM_W'(1);
        if (idx_max) state_d = COUNT;
      end
      COUNT: begin
        if (in_hs && in_last) begin
          state_d = DRAIN;
          idx_d   = '0;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          idx_d = idx + SYM_W'(1);
          if (idx_max) state_d = COUNT;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= CLEAR;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   total <= '0;
    else if (in_hs)            total <= total + TOT_W'(1);
    else if (out_hs && idx_max) total <= '0;
  end

`ifdef TALLY_SAT_EN
  logic ovf_mem [NSYM];
  logic at_max;

  assign at_max   = &cnt_cur;
  assign cnt_next = at_max ? cnt_cur : cnt_cur + CNT_W'(1);
  assign out_ovf  = (state == DRAIN) & ovf_mem[idx];

  always_ff @(posedge clk) begin
    if (state == CLEAR || out_hs) ovf_mem[idx]    <= 1'b0;
    else if (in_hs && at_max)     ovf_mem[in_sym] <= 1'b1;
  end
`else
  assign cnt_next = cnt_cur + CNT_W'(1);
  assign out_ovf  = 1'b0;
`endif

  // NOTE: the counter array has no reset; the CLEAR sweep after every reset zeroes it one entry per cycle.
  always_ff @(posedge clk) begin
    if (state == CLEAR || out_hs) cnt_mem[idx]    <= '0;
    else if (in_hs)               cnt_mem[in_sym] <= cnt_next;
  end

  assign in_ready  = (state == COUNT);
  assign busy      = (state != COUNT);
  assign out_valid = (state == DRAIN);
  assign out_sym   = out_valid ? idx : '0;
  assign out_count = out_valid ? cnt_mem[idx] : '0;
  assign out_last  = out_valid & idx_max;
  assign out_total = total;

endmodule

// File: tb/tb_symbol_tallier.sv
// Self-checking bench for symbol_tallier: table of frames with hand-derived counts, drain entries checked from a scoreboard queue.
module tb_symbol_tallier;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [3:0]  in_sym;
  logic        out_valid, out_ready, out_last, out_ovf, busy;
  logic [3:0]  out_sym;
  logic [7:0]  out_count;
  logic [11:0] out_total;

  symbol_tallier #(.SYM_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_count(out_count),
    .out_last(out_last), .out_total(out_total), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // {busy, sym, count, last, total, ovf}
  logic [26:0] sb [$];

  typedef struct packed {
    logic [3:0][3:0]  syms;
    logic [2:0]       n;
    logic [15:0][7:0] exp_cnt;
    logic [11:0]      exp_total;
  } frame_t;

  frame_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [26:0] dut_entry();
    return {busy, out_sym, out_count, out_last, out_total, out_ovf};
  endfunction

  task automatic push_expect(input logic [15:0][7:0] cnt, input logic [11:0] tot, input logic [15:0] ovf);
    for (int i = 0; i < 16; i++)
      sb.push_back({1'b1, 4'(i), cnt[i], (i == 15), tot, ovf[i]});
  endtask

  // Reset while between edges, confirm reset values, then measure the CLEAR length.
  task automatic do_reset();
    int n = 0;
    int bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_sym = '0; out_ready = 1'b0;
    #1;
    check("reset_outputs", {out_valid, out_sym, out_count, out_last, out_total, out_ovf, busy, in_ready},
          {1'b0, 4'd0, 8'd0, 1'b0, 12'd0, 1'b0, 1'b1, 1'b0});
    @(negedge clk);
    rst = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!in_ready && (out_valid || !busy)) bad++;
    end while (!in_ready && n < 40);
    check("clear_cycles", n, 16);
    check("clear_busy_outvalid", bad, 0);
    check("count_busy_low", busy, 1'b0);
  endtask

  task automatic send_sym(input logic [3:0] s, input logic last);
    int g = 0;
    while (!in_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) check("send_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_sym = s; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    if (last) check("first_entry_latency", out_valid, 1'b1);
  endtask

  // Idle cycles with in_valid=0 carry junk symbols and in_last=1, which must be ignored.
  task automatic send_frame(input frame_t f, input bit gap);
    push_expect(f.exp_cnt, f.exp_total, 16'h0000);
    for (int i = 0; i < int'(f.n); i++) begin
      if (gap) begin
        in_valid = 1'b0; in_sym = 4'($urandom); in_last = 1'b1;
        @(posedge clk); #1;
        in_last = 1'b0;
      end
      send_sym(f.syms[i], (i == int'(f.n) - 1));
    end
  endtask

  task automatic drain(input int stall_at, input int stall_len, input int abort_after);
    int k = 0;
    int guard = 0;
    logic [26:0] exp;
    out_ready = 1'b1;
    while (sb.size() > 0 && guard < 100 && k != abort_after) begin
      guard++;
      if (out_valid) begin
        exp = sb[0];
        check($sformatf("entry_%0d", k), dut_entry(), exp);
        if (k == stall_at) begin
          out_ready = 1'b0;
          repeat (stall_len) begin
            @(posedge clk); #1;
            check("stall_hold", dut_entry(), exp);
            check("stall_in_ready", in_ready, 1'b0);
          end
          out_ready = 1'b1;
        end
        @(posedge clk); #1;
        void'(sb.pop_front());
        k++;
      end else begin
        check("drain_valid", out_valid, 1'b1);
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b0;
    if (abort_after < 0) begin
      check("drain_empty", sb.size(), 0);
      check("post_drain_in_ready", in_ready, 1'b1);
      check("post_drain_out_valid", out_valid, 1'b0);
    end
  endtask

  initial begin
    logic [15:0][7:0] big_cnt;
    logic [15:0]      big_ovf;
    int               t0;

    tbl[0] = '0;
    tbl[0].syms[0] = 4'd3; tbl[0].syms[1] = 4'd3; tbl[0].syms[2] = 4'd5; tbl[0].syms[3] = 4'd15;
    tbl[0].n = 3'd4;
    tbl[0].exp_cnt[3] = 8'd2; tbl[0].exp_cnt[5] = 8'd1; tbl[0].exp_cnt[15] = 8'd1;
    tbl[0].exp_total = 12'd4;

    tbl[1] = '0;
    tbl[1].syms[0] = 4'd3; tbl[1].n = 3'd1;
    tbl[1].exp_cnt[3] = 8'd1; tbl[1].exp_total = 12'd1;

    tbl[2] = '0;
    tbl[2].syms[0] = 4'd0; tbl[2].n = 3'd1;
    tbl[2].exp_cnt[0] = 8'd1; tbl[2].exp_total = 12'd1;

    tbl[3] = '0;
    tbl[3].syms[0] = 4'd7; tbl[3].n = 3'd1;
    tbl[3].exp_cnt[7] = 8'd1; tbl[3].exp_total = 12'd1;

    do_reset();

    send_frame(tbl[0], 1'b0);
    drain(-1, 0, -1);

    send_frame(tbl[1], 1'b1);
    drain(-1, 0, -1);

    send_frame(tbl[0], 1'b0);
    drain(3, 5, -1);

    big_cnt = '0;
    big_ovf = '0;
`ifdef TALLY_SAT_EN
    big_cnt[0] = 8'd255;
    big_ovf[0] = 1'b1;
`else
    big_cnt[0] = 8'd1;
`endif
    push_expect(big_cnt, 12'd257, big_ovf);
    t0 = cyc;
    for (int i = 0; i < 257; i++) send_sym(4'd0, (i == 256));
    check("no_stall_cycles", cyc - t0, 257);
    drain(-1, 0, -1);

    send_frame(tbl[2], 1'b0);
    drain(-1, 0, -1);

    send_frame(tbl[0], 1'b0);
    drain(-1, 0, 4);
    check("abort_point_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    check("async_reset_out_valid", out_valid, 1'b0);
    sb.delete();
    do_reset();
    send_frame(tbl[3], 1'b0);
    drain(-1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
